// File: rtl/mc_controller.sv
// mc_controller: multicycle RV32I control FSM sequencing a shared ALU/memory/register datapath.
// Define MC_PERF_CNT_EN to build the retired-instruction counter (instret); otherwise instret is 0.
module mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             adr_src,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       imm_src,
  output logic [2:0]       alu_control,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, JAL, BEQ
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t     state, next_state;
  logic [1:0] alu_op;
  logic       pc_update, branch;
  logic       mem_req_s, ir_write_s, mem_write_s, reg_write_s, illegal_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= next_state;
  end

  always_comb begin
    next_state  = FETCH;
    mem_req_s   = 1'b0;
    adr_src     = 1'b0;
    ir_write_s  = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    illegal_s   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    case (state)
      FETCH: begin
        mem_req_s  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write_s = mem_ready;
        pc_update  = mem_ready;
        next_state = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECR;
          OP_I:         next_state = EXECI;
          OP_JAL:       next_state = JAL;
          OP_BEQ:       next_state = BEQ;
          default:      illegal_s  = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        next_state = (op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req_s  = 1'b1;
        adr_src    = 1'b1;
        next_state = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src  = 2'b01;
        reg_write_s = 1'b1;
      end
      MEMWRITE: begin
        mem_req_s   = 1'b1;
        adr_src     = 1'b1;
        mem_write_s = mem_ready;
        next_state  = mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        next_state = ALUWB;
      end
      EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        next_state = ALUWB;
      end
      ALUWB: reg_write_s = 1'b1;
      JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_update  = 1'b1;
        next_state = ALUWB;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end

  // Strobes are forced low while reset is held, even though the state register already reads FETCH.
  assign mem_req   = rst & mem_req_s;
  assign ir_write  = rst & ir_write_s;
  assign pc_write  = rst & (pc_update | (branch & zero));
  assign mem_write = rst & mem_write_s;
  assign reg_write = rst & reg_write_s;
  assign illegal   = rst & illegal_s;

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] instret_q;
  logic             retire;

  // An instruction retires on the cycle whose successor is a FETCH (illegal ops never reach here).
  assign retire = (state == MEMWB) | (state == ALUWB) | (state == BEQ) |
                  ((state == MEMWRITE) & mem_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        instret_q <= '0;
    else if (retire) instret_q <= instret_q + CNT_W'(1);
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: table-driven and randomized self-checking bench for mc_controller.
// Expected outputs come from a per-instruction step plan built from the instruction class.
module tb_mc_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic       clk, rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       mem_req, adr_src, pc_write, ir_write, mem_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] instret;

  int passCount = 0;
  int totalCount = 0;
  int retired = 0;

  typedef struct packed {
    logic       mem_req, adr_src, pc_write, ir_write, mem_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic       illegal;
  } outs_t;

  typedef enum {S_FETCH, S_DECODE, S_ADDR, S_LOAD, S_LOADWB, S_STORE,
                S_EXEC, S_WB, S_JUMP, S_BRANCH} step_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z;
    logic [2:0] alu3;
    int         cycles;
    logic       lastReg, lastPc;
    string      name;
  } vec_t;

  vec_t vecs[$];

  mc_controller #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src),
    .pc_write(pc_write), .ir_write(ir_write), .mem_write(mem_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control),
    .illegal(illegal), .instret(instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic isLegal(input logic [6:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
           (o == OP_JAL) || (o == OP_BEQ);
  endfunction

  function automatic logic [1:0] immFor(input logic [6:0] o);
    if (o == OP_SW)  return 2'b01;
    if (o == OP_BEQ) return 2'b10;
    if (o == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] aluFor(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000) return (o == OP_R && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic [3:0] expInstret();
`ifdef MC_PERF_CNT_EN
    return 4'(retired % 16);
`else
    return 4'd0;
`endif
  endfunction

  function automatic outs_t expOut(input step_t s, input logic mr, input logic z);
    outs_t o;
    o = '0;
    o.imm_src = immFor(op);
    case (s)
      S_FETCH:  begin o.mem_req = 1'b1; o.alu_src_b = 2'b10; o.result_src = 2'b10;
                      o.ir_write = mr; o.pc_write = mr; end
      S_DECODE: begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; o.illegal = !isLegal(op); end
      S_ADDR:   begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; end
      S_LOAD:   begin o.mem_req = 1'b1; o.adr_src = 1'b1; end
      S_LOADWB: begin o.result_src = 2'b01; o.reg_write = 1'b1; end
      S_STORE:  begin o.mem_req = 1'b1; o.adr_src = 1'b1; o.mem_write = mr; end
      S_EXEC:   begin o.alu_src_a = 2'b10; o.alu_src_b = (op == OP_R) ? 2'b00 : 2'b01;
                      o.alu_control = aluFor(op, funct3, funct7b5); end
      S_WB:     o.reg_write = 1'b1;
      S_JUMP:   begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.pc_write = 1'b1; end
      S_BRANCH: begin o.alu_src_a = 2'b10; o.alu_control = 3'b001; o.pc_write = z; end
      default:  o = '0;
    endcase
    return o;
  endfunction

  function automatic vec_t mkVec(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                 input logic z, input logic [2:0] a3, input int cyc,
                                 input logic lr, input logic lp, input string nm);
    vec_t v;
    v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.alu3 = a3;
    v.cycles = cyc; v.lastReg = lr; v.lastPc = lp; v.name = nm;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock cycle: drive inputs just after the edge, compare against the model at the falling edge.
  task automatic applyStimulus(input logic mr, input step_t s, input string tag);
    logic  z;
    outs_t act;
    z = 1'($urandom_range(0, 1));
    mem_ready = mr;
    zero = z;
    @(negedge clk);
    act = {mem_req, adr_src, pc_write, ir_write, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal};
    checkOutput({tag, "_outs"}, 32'(act), 32'(expOut(s, mr, z)));
    checkOutput({tag, "_instret"}, 32'(instret), 32'(expInstret()));
    @(posedge clk);
    #1;
  endtask

  task automatic runInstr(input logic [6:0] iop, input logic [2:0] if3, input logic if7,
                          input int fw, input int mw, input string tag);
    step_t plan[$];
    op = iop; funct3 = if3; funct7b5 = if7;
    plan.push_back(S_FETCH);
    plan.push_back(S_DECODE);
    case (iop)
      OP_LW:        begin plan.push_back(S_ADDR); plan.push_back(S_LOAD); plan.push_back(S_LOADWB); end
      OP_SW:        begin plan.push_back(S_ADDR); plan.push_back(S_STORE); end
      OP_R, OP_I:   begin plan.push_back(S_EXEC); plan.push_back(S_WB); end
      OP_JAL:       begin plan.push_back(S_JUMP); plan.push_back(S_WB); end
      OP_BEQ:       plan.push_back(S_BRANCH);
      default:      ;
    endcase
    foreach (plan[i]) begin
      if (plan[i] == S_FETCH || plan[i] == S_LOAD || plan[i] == S_STORE) begin
        int w;
        w = (plan[i] == S_FETCH) ? fw : mw;
        for (int k = 0; k < w; k++) applyStimulus(1'b0, plan[i], $sformatf("%s_s%0d_wait", tag, i));
        applyStimulus(1'b1, plan[i], $sformatf("%s_s%0d", tag, i));
      end else begin
        applyStimulus(1'($urandom_range(0, 1)), plan[i], $sformatf("%s_s%0d", tag, i));
      end
    end
    if (plan.size() > 2) retired++;
  endtask

  initial begin
    logic [2:0] seenAlu;
    logic       seenReg, seenPc;
    logic [6:0] rop;

    vecs.push_back(mkVec(OP_R,   3'b000, 1'b0, 1'b1, 3'b000, 4, 1'b1, 1'b0, "add"));
    vecs.push_back(mkVec(OP_R,   3'b000, 1'b1, 1'b0, 3'b001, 4, 1'b1, 1'b0, "sub"));
    vecs.push_back(mkVec(OP_R,   3'b010, 1'b0, 1'b0, 3'b101, 4, 1'b1, 1'b0, "slt"));
    vecs.push_back(mkVec(OP_R,   3'b110, 1'b0, 1'b1, 3'b011, 4, 1'b1, 1'b0, "or"));
    vecs.push_back(mkVec(OP_R,   3'b111, 1'b0, 1'b0, 3'b010, 4, 1'b1, 1'b0, "and"));
    vecs.push_back(mkVec(OP_R,   3'b100, 1'b1, 1'b0, 3'b000, 4, 1'b1, 1'b0, "f3_100"));
    vecs.push_back(mkVec(OP_I,   3'b000, 1'b1, 1'b0, 3'b000, 4, 1'b1, 1'b0, "addi_f7"));
    vecs.push_back(mkVec(OP_I,   3'b010, 1'b0, 1'b0, 3'b101, 4, 1'b1, 1'b0, "slti"));
    vecs.push_back(mkVec(OP_LW,  3'b010, 1'b0, 1'b0, 3'b000, 5, 1'b1, 1'b0, "lw"));
    vecs.push_back(mkVec(OP_SW,  3'b010, 1'b0, 1'b0, 3'b000, 4, 1'b0, 1'b0, "sw"));
    vecs.push_back(mkVec(OP_JAL, 3'b000, 1'b0, 1'b0, 3'b000, 4, 1'b1, 1'b0, "jal"));
    vecs.push_back(mkVec(OP_BEQ, 3'b000, 1'b0, 1'b1, 3'b001, 3, 1'b0, 1'b1, "beq_taken"));
    vecs.push_back(mkVec(OP_BEQ, 3'b000, 1'b0, 1'b0, 3'b001, 3, 1'b0, 1'b0, "beq_not"));

    rst = 1'b0; op = OP_R; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b1; mem_ready = 1'b1;
    #2;
    checkOutput("por_strobes", 32'({pc_write, ir_write, mem_write, reg_write, mem_req, illegal}), 32'd0);
    checkOutput("por_instret", 32'(instret), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset asserted while a load is waiting on memory.
    op = OP_LW; funct3 = 3'b010;
    applyStimulus(1'b1, S_FETCH, "rstseq_fetch");
    applyStimulus(1'b0, S_DECODE, "rstseq_decode");
    applyStimulus(1'b0, S_ADDR, "rstseq_addr");
    applyStimulus(1'b0, S_LOAD, "rstseq_load");
    mem_ready = 1'b0;
    #2;
    rst = 1'b0;
    retired = 0;
    @(negedge clk);
    checkOutput("rst_mid_strobes", 32'({pc_write, ir_write, mem_write, reg_write, mem_req, illegal}), 32'd0);
    checkOutput("rst_mid_instret", 32'(instret), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_fetch", 32'({mem_req, adr_src}), 32'b10);
    @(posedge clk);
    #1;
    retired++;
    // The fetch above was accepted; finish that load along the normal path.
    applyStimulus(1'b0, S_DECODE, "post_rst_decode");
    applyStimulus(1'b0, S_ADDR, "post_rst_addr");
    applyStimulus(1'b1, S_LOAD, "post_rst_load");
    applyStimulus(1'b0, S_LOADWB, "post_rst_wb");

    foreach (vecs[t]) begin
      op = vecs[t].op; funct3 = vecs[t].f3; funct7b5 = vecs[t].f7;
      zero = vecs[t].z; mem_ready = 1'b1;
      seenAlu = 3'bxxx; seenReg = 1'bx; seenPc = 1'bx;
      for (int c = 1; c <= vecs[t].cycles; c++) begin
        @(negedge clk);
        if (c == 3) seenAlu = alu_control;
        if (c == vecs[t].cycles) begin seenReg = reg_write; seenPc = pc_write; end
        @(posedge clk);
        #1;
      end
      checkOutput({vecs[t].name, "_alu_c3"}, 32'(seenAlu), 32'(vecs[t].alu3));
      checkOutput({vecs[t].name, "_last_reg_write"}, 32'(seenReg), 32'(vecs[t].lastReg));
      checkOutput({vecs[t].name, "_last_pc_write"}, 32'(seenPc), 32'(vecs[t].lastPc));
      retired++;
      mem_ready = 1'b0;
      @(negedge clk);
      checkOutput({vecs[t].name, "_refetch"}, 32'({mem_req, adr_src, ir_write}), 32'b100);
      checkOutput({vecs[t].name, "_instret"}, 32'(instret), 32'(expInstret()));
      @(posedge clk);
      #1;
    end

    runInstr(OP_LW, 3'b010, 1'b0, 0, 3, "lw_wait3");
    runInstr(OP_SW, 3'b010, 1'b0, 1, 2, "sw_wait");
    runInstr(7'b1111111, 3'b000, 1'b0, 0, 0, "illegal_ff");
    runInstr(OP_R, 3'b000, 1'b0, 0, 0, "after_illegal");

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 7))
        0: rop = OP_LW;
        1: rop = OP_SW;
        2: rop = OP_R;
        3: rop = OP_I;
        4: rop = OP_JAL;
        5: rop = OP_BEQ;
        6: rop = 7'($urandom_range(0, 127));
        default: rop = 7'b1111111;
      endcase
      runInstr(rop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), $urandom_range(0, 3), $sformatf("rand%0d", n));
    end

    // Seventeen adds from reset on a 4-bit counter.
    rst = 1'b0;
    retired = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int n = 0; n < 17; n++) runInstr(OP_R, 3'b000, 1'b0, 0, 0, $sformatf("wrap%0d", n));
    @(negedge clk);
`ifdef MC_PERF_CNT_EN
    checkOutput("instret_wrap17", 32'(instret), 32'd1);
`else
    checkOutput("instret_tied0", 32'(instret), 32'd0);
`endif

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
